// File: rtl/sb_io_if.sv
// Core-side signal bundle of the sb_io pin cell: control/data towards the pin
// and the captured input data coming back.
interface sb_io_if;
    logic CLOCK_ENABLE;
    logic LATCH_INPUT_VALUE;
    logic OUTPUT_ENABLE;
    logic D_OUT_0;
    logic D_OUT_1;
    logic D_IN_0;
    logic D_IN_1;

    modport master (
        output CLOCK_ENABLE,
        output LATCH_INPUT_VALUE,
        output OUTPUT_ENABLE,
        output D_OUT_0,
        output D_OUT_1,
        input  D_IN_0,
        input  D_IN_1
    );

    modport slave (
        input  CLOCK_ENABLE,
        input  LATCH_INPUT_VALUE,
        input  OUTPUT_ENABLE,
        input  D_OUT_0,
        input  D_OUT_1,
        output D_IN_0,
        output D_IN_1
    );
endinterface

// File: rtl/sb_io.sv
// Single-pin bidirectional I/O cell with an SB_IO-style configuration:
// selectable input, output-data and output-enable paths plus optional pull-up.
module sb_io #(
    parameter logic [5:0] PIN_TYPE    = 6'b000000,
    parameter logic       PULLUP      = 1'b0,
    parameter logic       NEG_TRIGGER = 1'b0
) (
    input  logic     clk,
    input  logic     rst,
    inout  wire      PACKAGE_PIN,
    sb_io_if.slave   core
);

    localparam logic [1:0] IN_REG       = 2'b00;
    localparam logic [1:0] IN_COMB      = 2'b01;
    localparam logic [1:0] IN_REG_LATCH = 2'b10;
    localparam logic [1:0] IN_LATCH     = 2'b11;

    localparam logic [1:0] OUT_DDR      = 2'b00;
    localparam logic [1:0] OUT_REG      = 2'b01;
    localparam logic [1:0] OUT_COMB     = 2'b10;
    localparam logic [1:0] OUT_REG_INV  = 2'b11;

    localparam logic [1:0] OE_NEVER     = 2'b00;
    localparam logic [1:0] OE_ALWAYS    = 2'b01;
    localparam logic [1:0] OE_COMB      = 2'b10;
    localparam logic [1:0] OE_REG       = 2'b11;

    localparam logic [1:0] IN_MODE  = PIN_TYPE[1:0];
    localparam logic [1:0] OUT_MODE = PIN_TYPE[3:2];
    localparam logic [1:0] OE_MODE  = PIN_TYPE[5:4];

    // "Rising" registers use clk_e's rising edge; NEG_TRIGGER swaps the edges.
    logic clk_e;
    assign clk_e = clk ^ NEG_TRIGGER;

    logic ce;
    logic latch_en;
    logic oe_in;
    logic in_hold;

    logic in0_q, in0_d;
    logic in1_q, in1_d;
    logic out0_q, out0_d;
    logic out1_q, out1_d;
    logic oe_q, oe_d;
    logic lat_q;

    logic drive_hi;
    logic drive_lo;
    logic drive;
    logic oe_act;
    logic pin_v;
    logic pin_rise;
    logic pin_fall;

    // Unconnected controls resolve to their inactive-safe defaults.
    always_comb begin
        ce       = (core.CLOCK_ENABLE !== 1'b0);
        latch_en = (core.LATCH_INPUT_VALUE === 1'b1);
        oe_in    = (core.OUTPUT_ENABLE === 1'b1);
        in_hold  = (IN_MODE == IN_REG_LATCH) && latch_en;
    end

    always_comb begin
        drive_hi = 1'b0;
        drive_lo = 1'b0;
        case (OUT_MODE)
            OUT_DDR: begin
                drive_hi = out0_q;
                drive_lo = out1_q;
            end
            OUT_REG: begin
                drive_hi = out0_q;
                drive_lo = out0_q;
            end
            OUT_REG_INV: begin
                drive_hi = ~out0_q;
                drive_lo = ~out0_q;
            end
            OUT_COMB: begin
                drive_hi = core.D_OUT_0;
                drive_lo = core.D_OUT_0;
            end
            default: begin
                drive_hi = 1'b0;
                drive_lo = 1'b0;
            end
        endcase
    end

    always_comb begin
        oe_act = 1'b0;
        case (OE_MODE)
            OE_NEVER:  oe_act = 1'b0;
            OE_ALWAYS: oe_act = 1'b1;
            OE_COMB:   oe_act = oe_in;
            OE_REG:    oe_act = oe_q;
            default:   oe_act = 1'b0;
        endcase
    end

    assign drive       = clk_e ? drive_hi : drive_lo;
    assign PACKAGE_PIN = oe_act ? drive : 1'bz;

    generate
        if (PULLUP) begin : g_pullup
            pullup u_pullup (PACKAGE_PIN);
        end
    endgenerate

    // When the cell drives a DDR pin itself, each input register samples the
    // half-cycle belonging to its own edge, avoiding a race with the output mux.
    always_comb begin
        pin_v    = oe_act ? drive    : PACKAGE_PIN;
        pin_rise = oe_act ? drive_hi : PACKAGE_PIN;
        pin_fall = oe_act ? drive_lo : PACKAGE_PIN;
    end

    always_comb begin
        out0_d = ce ? core.D_OUT_0 : out0_q;
        oe_d   = ce ? oe_in : oe_q;
        in0_d  = (ce && !in_hold) ? pin_rise : in0_q;
        out1_d = ce ? core.D_OUT_1 : out1_q;
        in1_d  = (ce && !in_hold) ? pin_fall : in1_q;
    end

    // Rising-edge register bank
    always_ff @(posedge clk_e) begin
        if (rst) begin
            out0_q <= 1'b0;
            oe_q   <= 1'b0;
            in0_q  <= 1'b0;
        end else begin
            out0_q <= out0_d;
            oe_q   <= oe_d;
            in0_q  <= in0_d;
        end
    end

    // Falling-edge register bank
    always_ff @(negedge clk_e) begin
        if (rst) begin
            out1_q <= 1'b0;
            in1_q  <= 1'b0;
        end else begin
            out1_q <= out1_d;
            in1_q  <= in1_d;
        end
    end

    // Transparent while LATCH_INPUT_VALUE is low, holds the pin value otherwise.
    always_latch begin
        if (!latch_en) begin
            lat_q <= pin_v;
        end
    end

    always_comb begin
        core.D_IN_0 = in0_q;
        core.D_IN_1 = in1_q;
        case (IN_MODE)
            IN_COMB: begin
                core.D_IN_0 = pin_v;
                core.D_IN_1 = 1'b0;
            end
            IN_LATCH: begin
                core.D_IN_0 = latch_en ? lat_q : pin_v;
                core.D_IN_1 = 1'b0;
            end
            IN_REG, IN_REG_LATCH: begin
                core.D_IN_0 = in0_q;
                core.D_IN_1 = in1_q;
            end
            default: begin
                core.D_IN_0 = in0_q;
                core.D_IN_1 = in1_q;
            end
        endcase
    end

endmodule

// File: tb/tb_sb_io.sv
// Randomized scoreboard bench for sb_io: six pin configurations share one
// stimulus stream; a behavioural model predicts pin and input data per half-cycle.
module tb_sb_io;

    localparam int N    = 6;
    localparam int NCYC = 320;
    localparam int SKIP = 3;
    // 0: button input, 1: reg out/in, 2: reg inverted out, 3: DDR out/in,
    // 4: registered OE + latchable registered in, 5: comb out/OE + latched in
    localparam logic [5:0] PT [N] = '{6'b101001, 6'b010100, 6'b011100,
                                      6'b010000, 6'b110110, 6'b101011};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic d0, d1, oe, lat, ce, ext_v;
    logic [N-1:0] ext_en;
    logic [N-1:0] pin_w, din0_w, din1_w;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            sb_io_if ifc ();
            wire pin;
            assign pin                   = ext_en[g] ? ext_v : 1'bz;
            assign ifc.CLOCK_ENABLE      = ce;
            assign ifc.LATCH_INPUT_VALUE = lat;
            assign ifc.OUTPUT_ENABLE     = oe;
            assign ifc.D_OUT_0           = d0;
            assign ifc.D_OUT_1           = d1;
            assign pin_w[g]              = pin;
            assign din0_w[g]             = ifc.D_IN_0;
            assign din1_w[g]             = ifc.D_IN_1;
            sb_io #(.PIN_TYPE(PT[g]), .PULLUP(1'b1), .NEG_TRIGGER(1'b0)) u_dut (
                .clk         (clk),
                .rst         (rst),
                .PACKAGE_PIN (pin),
                .core        (ifc)
            );
        end
    endgenerate

    // Model state: what each cell has stored, in the spec's own terms.
    logic m_out0 [N];
    logic m_out1 [N];
    logic m_oe   [N];
    logic m_in0  [N];
    logic m_in1  [N];
    logic m_held [N];

    typedef struct {
        int   cyc;
        bit   ph;
        int   k;
        logic pin;
        logic i0;
        logic i1;
    } exp_t;
    exp_t sbq [$];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic m_drive(int k, bit hi, logic dd0);
        case (PT[k][3:2])
            2'b10:   return dd0;
            2'b01:   return m_out0[k];
            2'b11:   return ~m_out0[k];
            default: return hi ? m_out0[k] : m_out1[k];
        endcase
    endfunction

    function automatic bit m_oe_act(int k, logic oein);
        case (PT[k][5:4])
            2'b00:   return 1'b0;
            2'b01:   return 1'b1;
            2'b10:   return oein;
            default: return m_oe[k];
        endcase
    endfunction

    // Pin value: own driver, else external driver, else the pull-up.
    function automatic logic m_pin(int k, bit hi, logic dd0, logic oein, logic een, logic ev);
        if (m_oe_act(k, oein)) return m_drive(k, hi, dd0);
        if (een) return ev;
        return 1'b1;
    endfunction

    function automatic exp_t m_expect(int c, bit hi, int k);
        exp_t e;
        logic p;
        p     = m_pin(k, hi, d0, oe, ext_en[k], ext_v);
        e.cyc = c;
        e.ph  = !hi;
        e.k   = k;
        e.pin = p;
        case (PT[k][1:0])
            2'b01: begin e.i0 = p; e.i1 = 1'b0; end
            2'b11: begin e.i0 = lat ? m_held[k] : p; e.i1 = 1'b0; end
            default: begin e.i0 = m_in0[k]; e.i1 = m_in1[k]; end
        endcase
        return e;
    endfunction

    // Stimulus + model
    initial begin
        logic p_d0, p_d1, p_oe, p_lat, p_ce, p_rst, p_ext_v;
        logic [N-1:0] p_ext_en;
        logic v;
        rst = 1'b1; ce = 1'b1; lat = 1'b0; d0 = 1'b0; d1 = 1'b0; oe = 1'b0;
        ext_en = '0; ext_v = 1'b0;
        for (int k = 0; k < N; k++) begin
            m_out0[k] = 1'b0; m_out1[k] = 1'b0; m_oe[k] = 1'b0;
            m_in0[k] = 1'b0; m_in1[k] = 1'b0; m_held[k] = 1'b1;
        end
        p_d0 = 0; p_d1 = 0; p_oe = 0; p_lat = 0; p_ce = 1; p_rst = 1;
        p_ext_v = 0; p_ext_en = '0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (p_rst) begin
                    m_out0[k] = 1'b0; m_oe[k] = 1'b0; m_in0[k] = 1'b0;
                end else if (p_ce) begin
                    v = m_pin(k, 1'b1, p_d0, p_oe, p_ext_en[k], p_ext_v);
                    m_out0[k] = p_d0;
                    m_oe[k]   = p_oe;
                    if (!(PT[k][1:0] == 2'b10 && p_lat)) m_in0[k] = v;
                end
                if (!p_lat) m_held[k] = m_pin(k, 1'b1, p_d0, p_oe, p_ext_en[k], p_ext_v);
            end
            lat = (c < SKIP + 1) ? 1'b0 : ($urandom_range(0, 3) == 0);
            #1;
            rst = (c < SKIP) || ($urandom_range(0, 19) == 0);
            ce  = (c < SKIP) ? 1'b1 : ($urandom_range(0, 3) != 0);
            d0  = 1'($urandom_range(0, 1));
            d1  = 1'($urandom_range(0, 1));
            oe  = 1'($urandom_range(0, 1));
            ext_v = 1'($urandom_range(0, 1));
            ext_en[0] = !oe && ($urandom_range(0, 1) == 1);
            ext_en[5] = !oe && ($urandom_range(0, 1) == 1);
            for (int k = 0; k < N; k++) begin
                if (!lat) m_held[k] = m_pin(k, 1'b1, d0, oe, ext_en[k], ext_v);
                if (c >= SKIP) sbq.push_back(m_expect(c, 1'b1, k));
            end
            for (int k = 0; k < N; k++) begin
                if (rst) begin
                    m_out1[k] = 1'b0; m_in1[k] = 1'b0;
                end else if (ce) begin
                    v = m_pin(k, 1'b0, d0, oe, ext_en[k], ext_v);
                    m_out1[k] = d1;
                    if (!(PT[k][1:0] == 2'b10 && lat)) m_in1[k] = v;
                end
                if (c >= SKIP) sbq.push_back(m_expect(c, 1'b0, k));
            end
            p_d0 = d0; p_d1 = d1; p_oe = oe; p_lat = lat; p_ce = ce; p_rst = rst;
            p_ext_v = ext_v; p_ext_en = ext_en;
        end
    end

    task automatic cmp_bit(string nm, int k, int c, bit ph, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d cyc%0d ph%0d: got %b expected %b", nm, k, c, ph, act, exp);
        end
    endtask

    task automatic check_phase(int c, bit ph);
        exp_t e;
        int popped = 0;
        while (sbq.size() > 0 && (sbq[0].cyc < c || (sbq[0].cyc == c && sbq[0].ph <= ph))) begin
            e = sbq.pop_front();
            if (e.cyc != c || e.ph != ph) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stale dut%0d: entry cyc%0d ph%0d seen at cyc%0d ph%0d", e.k, e.cyc, e.ph, c, ph);
            end else begin
                popped++;
                cmp_bit("pin",  e.k, c, ph, pin_w[e.k],  e.pin);
                cmp_bit("din0", e.k, c, ph, din0_w[e.k], e.i0);
                cmp_bit("din1", e.k, c, ph, din1_w[e.k], e.i1);
            end
        end
        if (c >= SKIP && popped != N) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing cyc%0d ph%0d: got %0d entries expected %0d", c, ph, popped, N);
        end
    endtask

    // Monitor: samples mid-way into each half-cycle
    initial begin
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #3;
            check_phase(c, 1'b0);
            @(negedge clk);
            #3;
            check_phase(c, 1'b1);
        end
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: got %0d entries expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
